// File: rtl/counter_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_bank_pkg
//  Description : Shared definitions for the counter bank: overflow mode
//                constants, the per-cycle count action encoding and a helper
//                for locating channel slices inside packed bus vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_bank_pkg;

    // Overflow handling selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;   // wrap modulo 2^WIDTH
    localparam int MODE_SAT  = 1;   // clamp at 0 / max

    // The single action a channel's counter takes in a given cycle
    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_CLR  = 3'd1,
        ACT_LOAD = 3'd2,
        ACT_INC  = 3'd3,
        ACT_DEC  = 3'd4
    } act_e;

    // LSB position of channel ch inside a bus packed as N x w-bit fields
    function automatic int unsigned slice_lsb(input int unsigned ch,
                                              input int unsigned w);
        return ch * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_bank_ch.sv
`default_nettype none
// ============================================================================
//  Module      : counter_bank_ch
//  Description : One counter channel: free-running prescaler, prioritised
//                up/down counter with wrap or saturate overflow, registered
//                zero / compare flags and a one-cycle overflow pulse.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                i_clr/i_load        - sync clear, parallel load strobe
//                i_en/i_auto_en      - count enable, prescaler up-count enable
//                i_up/i_down         - single-cycle step pulses
//                i_load_val/i_cmp_val/i_div_val - load, compare, reload values
//                o_count/o_eq_zero/o_eq_cmp/o_ovf - state and flags
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_bank_ch
    import counter_bank_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 24,
    parameter int SATURATE   = MODE_WRAP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic                  i_auto_en,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_load_val,
    input  logic [WIDTH-1:0]      i_cmp_val,
    input  logic [PRESCALE_W-1:0] i_div_val,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_eq_zero,
    output logic                  o_eq_cmp,
    output logic                  o_ovf
);

    localparam logic [WIDTH-1:0]      c_max     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]      c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] c_pre_one = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] pre_q,   pre_d;
    logic                  tick_q,  tick_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic                  ovf_q,   ovf_d;
    logic                  eq_zero_q, eq_zero_d;
    logic                  eq_cmp_q,  eq_cmp_d;
    act_e                  act;

    // Prescaler: reloads from the live div_val only when it reaches zero,
    // so a new divisor takes effect at the next reload.
    always_comb begin
        pre_d  = pre_q - c_pre_one;
        tick_d = 1'b0;
        if (pre_q == '0) begin
            pre_d  = i_div_val;
            tick_d = 1'b1;
        end
    end

    // Action select; up together with down cancels both steps and
    // also suppresses the auto tick.
    always_comb begin
        act = ACT_HOLD;
        if (i_clr)
            act = ACT_CLR;
        else if (i_load)
            act = ACT_LOAD;
        else if (i_en && (i_up ^ i_down))
            act = i_up ? ACT_INC : ACT_DEC;
        else if (i_en && i_auto_en && tick_q && !i_up && !i_down)
            act = ACT_INC;
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unique case (act)
            ACT_CLR:  count_d = '0;
            ACT_LOAD: count_d = i_load_val;
            ACT_INC: begin
                if (count_q == c_max) begin
                    ovf_d   = 1'b1;
                    count_d = (SATURATE == MODE_WRAP) ? '0 : count_q;
                end else begin
                    count_d = count_q + c_one;
                end
            end
            ACT_DEC: begin
                if (count_q == '0) begin
                    ovf_d   = 1'b1;
                    count_d = (SATURATE == MODE_WRAP) ? c_max : count_q;
                end else begin
                    count_d = count_q - c_one;
                end
            end
            default:  count_d = count_q;
        endcase
    end

    // Flags compare the registered count, hence one cycle behind it
    always_comb begin
        eq_zero_d = (count_q == '0);
        eq_cmp_d  = (count_q == i_cmp_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            tick_q    <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            eq_zero_q <= 1'b1;
            eq_cmp_q  <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            eq_zero_q <= eq_zero_d;
            eq_cmp_q  <= eq_cmp_d;
        end
    end

    assign o_count   = count_q;
    assign o_eq_zero = eq_zero_q;
    assign o_eq_cmp  = eq_cmp_q;
    assign o_ovf     = ovf_q;

endmodule
`default_nettype wire

// File: rtl/counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : counter_bank
//  Description : Bank of N_CH independent prescaled up/down counters. This
//                level only slices the packed host buses per channel and
//                packs the channel results back.
//  Ports       : sys_clk, reset_n   - clock, async active-low reset
//                clr/en/auto_en/up/down/load - per-channel controls (N_CH)
//                load_val/cmp_val   - N_CH x WIDTH packed values
//                div_val            - N_CH x PRESCALE_W packed reload values
//                count              - N_CH x WIDTH packed counts
//                eq_zero/eq_cmp/ovf - per-channel flags
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 24,
    parameter int SATURATE   = MODE_WRAP
) (
    input  logic                       sys_clk,
    input  logic                       reset_n,
    input  logic [N_CH-1:0]            clr,
    input  logic [N_CH-1:0]            en,
    input  logic [N_CH-1:0]            auto_en,
    input  logic [N_CH-1:0]            up,
    input  logic [N_CH-1:0]            down,
    input  logic [N_CH-1:0]            load,
    input  logic [N_CH*WIDTH-1:0]      load_val,
    input  logic [N_CH*WIDTH-1:0]      cmp_val,
    input  logic [N_CH*PRESCALE_W-1:0] div_val,
    output logic [N_CH*WIDTH-1:0]      count,
    output logic [N_CH-1:0]            eq_zero,
    output logic [N_CH-1:0]            eq_cmp,
    output logic [N_CH-1:0]            ovf
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        counter_bank_ch #(
            .WIDTH      (WIDTH),
            .PRESCALE_W (PRESCALE_W),
            .SATURATE   (SATURATE)
        ) u_ch (
            .clk        (sys_clk),
            .rst_n      (reset_n),
            .i_clr      (clr[i]),
            .i_en       (en[i]),
            .i_auto_en  (auto_en[i]),
            .i_up       (up[i]),
            .i_down     (down[i]),
            .i_load     (load[i]),
            .i_load_val (load_val[slice_lsb(i, WIDTH) +: WIDTH]),
            .i_cmp_val  (cmp_val[slice_lsb(i, WIDTH) +: WIDTH]),
            .i_div_val  (div_val[slice_lsb(i, PRESCALE_W) +: PRESCALE_W]),
            .o_count    (count[slice_lsb(i, WIDTH) +: WIDTH]),
            .o_eq_zero  (eq_zero[i]),
            .o_eq_cmp   (eq_cmp[i]),
            .o_ovf      (ovf[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_bank
//  Description : Directed self-checking bench for counter_bank: a 4-channel
//                wrapping instance and a 1-channel saturating instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_bank;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  clr, en, auto_en, up, down, load;
    logic [31:0] load_val, cmp_val;
    logic [95:0] div_val;
    logic [31:0] count;
    logic [3:0]  eq_zero, eq_cmp, ovf;

    logic [0:0]  s_clr, s_en, s_auto_en, s_up, s_down, s_load;
    logic [7:0]  s_load_val, s_cmp_val, s_div_val, s_count;
    logic [0:0]  s_eq_zero, s_eq_cmp, s_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    counter_bank #(.N_CH(4), .WIDTH(8), .PRESCALE_W(24), .SATURATE(0)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .clr(clr), .en(en),
        .auto_en(auto_en), .up(up), .down(down), .load(load),
        .load_val(load_val), .cmp_val(cmp_val), .div_val(div_val),
        .count(count), .eq_zero(eq_zero), .eq_cmp(eq_cmp), .ovf(ovf)
    );

    counter_bank #(.N_CH(1), .WIDTH(8), .PRESCALE_W(8), .SATURATE(1)) dut_sat (
        .sys_clk(sys_clk), .reset_n(reset_n), .clr(s_clr), .en(s_en),
        .auto_en(s_auto_en), .up(s_up), .down(s_down), .load(s_load),
        .load_val(s_load_val), .cmp_val(s_cmp_val), .div_val(s_div_val),
        .count(s_count), .eq_zero(s_eq_zero), .eq_cmp(s_eq_cmp), .ovf(s_ovf)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        clr = '0; en = '0; auto_en = '0; up = '0; down = '0; load = '0;
        load_val = '0; cmp_val = '0; div_val = '0;
        s_clr = '0; s_en = '0; s_auto_en = '0; s_up = '0; s_down = '0;
        s_load = '0; s_load_val = '0; s_cmp_val = '0; s_div_val = '0;

        // ch0 auto count with a divide-by-4 prescaler
        en[0] = 1'b1; auto_en[0] = 1'b1; div_val[23:0] = 24'd3;

        #23;
        check("rst_count",   count,   32'h0);
        check("rst_eq_zero", eq_zero, 4'hF);
        check("rst_eq_cmp",  eq_cmp,  4'h0);
        check("rst_ovf",     ovf,     4'h0);
        reset_n = 1'b1;

        step();                                   // edge 1: tick registered
        check("auto_e1", count[7:0], 8'h00);
        step();                                   // edge 2: first increment
        check("auto_e2", count[7:0], 8'h01);
        check("eqz_lag", eq_zero[0], 1'b1);
        step();
        check("eqz_fall", eq_zero[0], 1'b0);
        repeat (3) step();                        // edge 6
        check("auto_e6", count[7:0], 8'h02);
        repeat (4) step();                        // edge 10
        check("auto_e10", count[7:0], 8'h03);
        check("idle_ch", count[31:8], 32'h0);
        en[0] = 1'b0;

        // ch1 wrap at 0xFF / 0x00
        load[1] = 1'b1; load_val[15:8] = 8'hFF; en[1] = 1'b1;
        step();
        check("ld_ff", count[15:8], 8'hFF);
        check("ld_no_ovf", ovf[1], 1'b0);
        load[1] = 1'b0; up[1] = 1'b1;
        step();
        check("wrap_up", count[15:8], 8'h00);
        check("wrap_up_ovf", ovf[1], 1'b1);
        up[1] = 1'b0;
        step();
        check("ovf_1cyc", ovf[1], 1'b0);
        down[1] = 1'b1;
        step();
        check("wrap_dn", count[15:8], 8'hFF);
        check("wrap_dn_ovf", ovf[1], 1'b1);
        down[1] = 1'b0;
        step();
        check("ovf_1cyc2", ovf[1], 1'b0);

        // ch2 simultaneous events (div_val = 0: tick every cycle)
        load[2] = 1'b1; load_val[23:16] = 8'h10;
        step();
        check("ld_10", count[23:16], 8'h10);
        load[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b1; down[2] = 1'b1; clr[2] = 1'b1;
        step();
        check("clr_wins", count[23:16], 8'h00);
        check("clr_no_ovf", ovf[2], 1'b0);
        clr[2] = 1'b0; up[2] = 1'b0; down[2] = 1'b0;
        load[2] = 1'b1; load_val[23:16] = 8'h05; auto_en[2] = 1'b1;
        step();
        check("ld_05", count[23:16], 8'h05);
        load[2] = 1'b0; up[2] = 1'b1; down[2] = 1'b1;
        step();
        check("updn_hold", count[23:16], 8'h05);
        up[2] = 1'b0; down[2] = 1'b0;
        step();
        check("tick_live", count[23:16], 8'h06);
        auto_en[2] = 1'b0; en[2] = 1'b0;

        // ch3 disabled channel: load wins, steps ignored, compare flag
        auto_en[3] = 1'b1; load[3] = 1'b1; load_val[31:24] = 8'h7F;
        cmp_val[31:24] = 8'h7F;
        step();
        check("ld_7f", count[31:24], 8'h7F);
        check("cmp_lag", eq_cmp[3], 1'b0);
        load[3] = 1'b0;
        step();
        check("en0_hold", count[31:24], 8'h7F);
        check("cmp_hit", eq_cmp[3], 1'b1);
        up[3] = 1'b1;
        step();
        check("en0_noup", count[31:24], 8'h7F);
        up[3] = 1'b0; auto_en[3] = 1'b0;

        // Async reset mid-operation: ch0 at 0x42, ch1 wrapping with ovf high
        load[0] = 1'b1; load_val[7:0] = 8'h42; up[1] = 1'b1;
        step();
        check("ld_42", count[7:0], 8'h42);
        check("pre_rst_ovf", ovf[1], 1'b1);
        load[0] = 1'b0; up[1] = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("async_count", count, 32'h0);
        check("async_ovf", ovf, 4'h0);
        check("async_eqz", eq_zero, 4'hF);
        en = 4'b0001; auto_en = 4'b0001; div_val = '0;
        #1;
        reset_n = 1'b1;
        step();
        check("rel_e1", count[7:0], 8'h00);
        step();
        check("rel_e2", count[7:0], 8'h01);
        step();
        check("rel_e3", count[7:0], 8'h02);
        en = '0; auto_en = '0;

        // Saturating instance
        s_en = 1'b1; s_load = 1'b1; s_load_val = 8'h00;
        step();
        check("sat_ld0", s_count, 8'h00);
        s_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_down = 1'b1;
            step();
            check("sat_dn", s_count, 8'h00);
            check("sat_dn_ovf", s_ovf, 1'b1);
            s_down = 1'b0;
            step();
            check("sat_dn_ovf0", s_ovf, 1'b0);
        end
        s_up = 1'b1;
        step();
        check("sat_up", s_count, 8'h01);
        check("sat_up_ovf", s_ovf, 1'b0);
        s_up = 1'b0; s_load = 1'b1; s_load_val = 8'hFF;
        step();
        s_load = 1'b0; s_up = 1'b1;
        step();
        check("sat_max", s_count, 8'hFF);
        check("sat_max_ovf", s_ovf, 1'b1);
        s_up = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
